clkdiv_sched: RTL and testbench

Ratio scheduler and glitch-free programmable clock divider for the switch-selected divider path. It synchronises and filters the 2-bit `sw` selection, then schedules each ratio change so that it takes effect only at a `clk_out` period boundary. This prevents runt or stretched pulses. It sits between the board switches and any logic clocked or enabled by `clk_out`.

---
 rtl/clkdiv_sched.sv | 123 ++++++++++++
 tb/tb_clkdiv_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_sched.sv
// Switch-selected glitch-free clock divider.
// Ratio changes are filtered, then applied only at a clk_out period boundary.
module clkdiv_sched #(
    parameter int DIV0   = 2,
    parameter int DIV1   = 4,
    parameter int DIV2   = 8,
    parameter int DIV3   = 16,
    parameter int STABLE = 4,
    parameter int CW     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic       clk_out,
    output logic [1:0] sel_cur,
    output logic       busy,
    output logic       chg
);

    typedef enum logic [1:0] {IDLE, SETTLE, PEND} state_t;

    localparam int SCW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [SCW-1:0] ST_LAST = SCW'(STABLE - 1);
    localparam logic [CW-1:0]  HM0 = CW'(DIV0 / 2 - 1);
    localparam logic [CW-1:0]  HM1 = CW'(DIV1 / 2 - 1);
    localparam logic [CW-1:0]  HM2 = CW'(DIV2 / 2 - 1);
    localparam logic [CW-1:0]  HM3 = CW'(DIV3 / 2 - 1);

    logic [1:0]     sw_m, sw_s;
    logic [CW-1:0]  cnt, half_m1;
    state_t         state, state_d;
    logic [SCW-1:0] st_cnt, st_cnt_d;
    logic [1:0]     sel_nxt, sel_nxt_d;
    logic           boundary, apply;

    always_comb begin
        half_m1 = HM0;
        case (sel_cur)
            2'b00: half_m1 = HM0;
            2'b01: half_m1 = HM1;
            2'b10: half_m1 = HM2;
            2'b11: half_m1 = HM3;
            default: half_m1 = HM0;
        endcase
    end

    // Boundary is the falling edge that closes a full period.
    assign boundary = (cnt == half_m1) && clk_out;
    assign apply    = (state == PEND) && boundary;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m <= 2'b00;
            sw_s <= 2'b00;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            sel_cur <= 2'b00;
            chg     <= 1'b0;
        end else begin
            if (cnt == half_m1) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + 1'b1;
            end
            chg <= apply;
            if (apply) sel_cur <= sel_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            st_cnt  <= '0;
            sel_nxt <= 2'b00;
        end else begin
            state   <= state_d;
            st_cnt  <= st_cnt_d;
            sel_nxt <= sel_nxt_d;
        end
    end

    always_comb begin
        state_d   = state;
        st_cnt_d  = st_cnt;
        sel_nxt_d = sel_nxt;
        case (state)
            IDLE: begin
                if (sw_s != sel_cur) begin
                    sel_nxt_d = sw_s;
                    st_cnt_d  = '0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (sw_s == sel_cur) begin
                    state_d = IDLE;
                end else if (sw_s != sel_nxt) begin
                    sel_nxt_d = sw_s;
                    st_cnt_d  = '0;
                end else if (st_cnt == ST_LAST) begin
                    state_d = PEND;
                end else begin
                    st_cnt_d = st_cnt + 1'b1;
                end
            end
            PEND: begin
                if (apply) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched: stimulus queues expected ratio changes,
// a monitor checks every chg pulse and every clk_out phase length.
module tb_clkdiv_sched;

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw  = 2'b00;
    logic       clk_out;
    logic [1:0] sel_cur;
    logic       busy;
    logic       chg;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    clkdiv_sched dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .clk_out (clk_out),
        .sel_cur (sel_cur),
        .busy    (busy),
        .chg     (chg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int half_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    task automatic wait_until(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: phase lengths and chg events.
    initial begin
        logic last_clk;
        int   last_edge;
        int   exp_half;
        exp_t e;
        last_clk  = 1'b0;
        last_edge = 0;
        exp_half  = 1;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                last_clk  = 1'b0;
                last_edge = 0;
                exp_half  = 1;
            end else begin
                if (clk_out !== last_clk) begin
                    check("phase_len", cyc - last_edge, exp_half);
                    last_edge = cyc;
                    last_clk  = clk_out;
                end
                if (chg === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_chg", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("chg_cycle", cyc, e.cyc);
                        check("chg_sel", {30'd0, sel_cur}, {30'd0, e.sel});
                        check("chg_clk_out", {31'd0, clk_out}, 0);
                        exp_half = half_of(e.sel);
                    end
                end
            end
        end
    end

    initial begin
        // reset and idle at DIV0
        repeat (3) @(negedge clk);
        check("rst_clk_out", {31'd0, clk_out}, 0);
        check("rst_sel", {30'd0, sel_cur}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_chg", {31'd0, chg}, 0);
        rst = 1'b0;
        wait_until(1);
        check("first_rise", {31'd0, clk_out}, 1);
        wait_until(30);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_sel", {30'd0, sel_cur}, 0);

        // 00 -> 01
        sw = 2'b01;
        q.push_back('{2'b01, 38});
        wait_until(32);
        check("b_busy_pre", {31'd0, busy}, 0);
        wait_until(33);
        check("b_busy_set", {31'd0, busy}, 1);
        wait_until(48);
        check("b_sel", {30'd0, sel_cur}, 1);
        check("b_busy_end", {31'd0, busy}, 0);

        // 01 -> 11 briefly, then withdrawn
        sw = 2'b11;
        wait_until(50);
        sw = 2'b01;
        wait_until(51);
        check("d_busy_on", {31'd0, busy}, 1);
        wait_until(53);
        check("d_busy_off", {31'd0, busy}, 0);
        wait_until(60);
        check("d_sel", {30'd0, sel_cur}, 1);

        // 10 for 2 clocks then 11: settle restarts
        sw = 2'b10;
        wait_until(62);
        sw = 2'b11;
        q.push_back('{2'b11, 70});
        wait_until(63);
        check("c_busy_on", {31'd0, busy}, 1);
        wait_until(69);
        check("c_busy_pend", {31'd0, busy}, 1);
        wait_until(71);
        check("c_busy_off", {31'd0, busy}, 0);
        check("c_sel", {30'd0, sel_cur}, 3);

        // 11 -> 00 requested at cnt=2 of a high phase
        wait_until(112);
        check("e_clk_high", {31'd0, clk_out}, 1);
        sw = 2'b00;
        q.push_back('{2'b00, 134});
        wait_until(140);
        check("e_sel", {30'd0, sel_cur}, 0);
        check("e_busy", {31'd0, busy}, 0);

        // reset while a change to 10 is pending
        sw = 2'b10;
        wait_until(147);
        check("f_busy_pend", {31'd0, busy}, 1);
        check("f_clk_pre", {31'd0, clk_out}, 1);
        #1 rst = 1'b1;
        #2;
        check("f_rst_clk_out", {31'd0, clk_out}, 0);
        check("f_rst_sel", {30'd0, sel_cur}, 0);
        check("f_rst_busy", {31'd0, busy}, 0);
        check("f_rst_chg", {31'd0, chg}, 0);
        #1 rst = 1'b0;
        q.push_back('{2'b10, 8});
        wait_until(1);
        check("f_first_rise", {31'd0, clk_out}, 1);
        wait_until(3);
        check("f_busy_on", {31'd0, busy}, 1);
        wait_until(30);
        check("f_sel", {30'd0, sel_cur}, 2);
        check("f_busy_end", {31'd0, busy}, 0);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
